// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module      : uart_pkg
// Description : Shared definitions for the UART message transmitter: default
//               clock and line rates, bit-period helper, message ROM and the
//               sequencer state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int CLK_FREQ_DEFAULT = 100_000_000;
    localparam int BAUD_DEFAULT     = 115_200;

    localparam int MSG_LEN = 7;

    // "HELLO\r\n", index 0 is the first byte on the line.
    localparam logic [0:MSG_LEN-1][7:0] MSG_ROM = {
        8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A
    };

    typedef enum logic [1:0] {
        SEQ_WAIT  = 2'd0,
        SEQ_START = 2'd1,
        SEQ_SEND  = 2'd2,
        SEQ_NEXT  = 2'd3
    } seq_state_t;

    // Clock cycles per serial bit; integer division truncates.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module      : uart_tx
// Description : 8N1 byte serialiser. A tx_start pulse while idle latches
//               tx_data and sends start bit, d0..d7 (LSB first), stop bit,
//               each held CLKS_PER_BIT cycles. tx_start is ignored while busy.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               tx_start      - request to send tx_data (1-cycle pulse)
//               tx_data[7:0]  - byte to send
//               tx_busy       - high while a frame is in progress
//               tx_done       - 1-cycle pulse in the last cycle of stop bit
//               dout          - registered serial line, idle high
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       dout
);

    localparam int                 c_cnt_w    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_data  = 2'd2;
    localparam logic [1:0] c_stop  = 2'd3;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [c_cnt_w-1:0] r_baud_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_dout;
    logic               w_bit_end;

    assign w_bit_end = (r_baud_cnt == c_cnt_last);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_idle:  if (tx_start)                       w_state_next = c_start;
            c_start: if (w_bit_end)                      w_state_next = c_data;
            c_data:  if (w_bit_end && r_bit_idx == 3'd7) w_state_next = c_stop;
            c_stop:  if (w_bit_end)                      w_state_next = c_idle;
            default:                                     w_state_next = c_idle;
        endcase
    end

    // Outputs
    always_comb begin
        tx_busy = (r_state != c_idle);
        tx_done = (r_state == c_stop) && w_bit_end;
        dout    = r_dout;
    end

    // Bit timing and line register. The line value for the next bit is
    // loaded on the same edge that ends the current bit, so dout never
    // depends combinationally on state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_dout     <= 1'b1;
        end else if (r_state == c_idle) begin
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            if (tx_start) begin
                r_shift <= tx_data;
                r_dout  <= 1'b0;
            end else begin
                r_dout  <= 1'b1;
            end
        end else if (!w_bit_end) begin
            r_baud_cnt <= r_baud_cnt + 1'b1;
        end else begin
            r_baud_cnt <= '0;
            if (r_state == c_start) begin
                r_dout  <= r_shift[0];
                r_shift <= {1'b0, r_shift[7:1]};
            end else if (r_state == c_data && r_bit_idx != 3'd7) begin
                r_dout    <= r_shift[0];
                r_shift   <= {1'b0, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end else begin
                // End of d7 enters the stop bit; end of stop stays high.
                r_dout <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_send_top.sv
//------------------------------------------------------------------------------
// Module      : uart_send_top
// Description : Repeatedly transmits the ROM message "HELLO\r\n" as 8N1
//               frames, one message start every PERIOD_CYCLES clocks. The
//               first message begins right after reset is released.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               dout - UART TX line, idle high
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_send_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ      = CLK_FREQ_DEFAULT,
    parameter int BAUD          = BAUD_DEFAULT,
    parameter int PERIOD_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic dout
);

    localparam int                 c_cpb      = clks_per_bit(CLK_FREQ, BAUD);
    localparam int                 c_per_w    = $clog2(PERIOD_CYCLES);
    localparam logic [c_per_w-1:0] c_per_last = c_per_w'(PERIOD_CYCLES - 1);
    localparam int                 c_idx_w    = $clog2(MSG_LEN);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(MSG_LEN - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_next;
    logic [c_per_w-1:0] r_period_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic               w_period_wrap;
    logic               w_period_hold;
    logic               w_tx_start;
    logic [7:0]         w_tx_data;
    logic               w_tx_busy;
    logic               w_tx_done;

    // The counter sits at zero only between reset and the first START; from
    // then on it free-runs, so every message starts exactly one period after
    // the previous one. WAIT exits on the cycle the counter wraps, giving the
    // same START phase as the post-reset start.
    assign w_period_wrap = (r_period_cnt == c_per_last);
    assign w_period_hold = (r_state == SEQ_WAIT) && (r_period_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (!w_period_hold) begin
            r_period_cnt <= w_period_wrap ? '0 : r_period_cnt + 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_WAIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEQ_WAIT:  if (r_period_cnt == '0 || w_period_wrap) w_state_next = SEQ_START;
            SEQ_START: if (!w_tx_busy)                          w_state_next = SEQ_SEND;
            SEQ_SEND:  if (w_tx_done)                           w_state_next = SEQ_NEXT;
            SEQ_NEXT:  w_state_next = (r_idx == c_idx_last) ? SEQ_WAIT : SEQ_START;
            default:   w_state_next = SEQ_WAIT;
        endcase
    end

    // Outputs
    always_comb begin
        w_tx_start = (r_state == SEQ_START) && !w_tx_busy;
        w_tx_data  = MSG_ROM[r_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if (r_state == SEQ_NEXT) begin
            r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT (c_cpb)
    ) u_uart_tx (
        .clk      (clk),
        .rst      (rst),
        .tx_start (w_tx_start),
        .tx_data  (w_tx_data),
        .tx_busy  (w_tx_busy),
        .tx_done  (w_tx_done),
        .dout     (dout)
    );

endmodule

`default_nettype wire

// File: tb/tb_uart_send_top.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_send_top
// Description : Self-checking bench for uart_send_top. Two instances with
//               reduced rates (8 and 10 clocks per bit) are compared every
//               cycle against an arithmetic line model, and their messages
//               are decoded and timed against hand-computed values.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_send_top;

    localparam int CF     = 1_000_000;
    localparam int BAUD_A = 115_200;   // 1e6/115200 = 8.68 -> 8
    localparam int BAUD_B = 96_000;    // 1e6/96000  = 10.4 -> 10
    localparam int CPB_A  = 8;
    localparam int CPB_B  = 10;
    localparam int PER_A  = 700;
    localparam int PER_B  = 900;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dout_a;
    logic dout_b;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int k        = -2;   // edges since reset release; -1 in reset, -2 before any edge
    int last_rise [2];
    logic prev_d [2];

    logic [7:0] msg [7] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h0D, 8'h0A};

    always #5 clk = ~clk;

    uart_send_top #(.CLK_FREQ(CF), .BAUD(BAUD_A), .PERIOD_CYCLES(PER_A)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .dout (dout_a)
    );

    uart_send_top #(.CLK_FREQ(CF), .BAUD(BAUD_B), .PERIOD_CYCLES(PER_B)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .dout (dout_b)
    );

    // Expected line value after edge kk counted from the first edge with
    // rst low: message starts at kk=1 and repeats every per cycles; each
    // byte slot is a 10-bit frame followed by 2 idle cycles.
    function automatic logic exp_dout(input int kk, input int cpb, input int per);
        int o, slot, b, r, bp;
        if (kk <= 0) return 1'b1;
        o    = (kk - 1) % per;
        slot = 10 * cpb + 2;
        b    = o / slot;
        r    = o % slot;
        if (b >= 7 || r >= 10 * cpb) return 1'b1;
        bp = r / cpb;
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return msg[b][bp-1];
    endfunction

    function automatic logic sig(input int sel);
        return (sel != 0) ? dout_b : dout_a;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst)        k <= -1;
        else if (k < 0) k <= 0;
        else            k <= k + 1;
    end

    // Per-cycle comparison against the line model, plus rising-edge tracking.
    always @(negedge clk) begin
        if (k >= -1) begin
            check_bit("model_dout_a", dout_a, exp_dout(k, CPB_A, PER_A));
            check_bit("model_dout_b", dout_b, exp_dout(k, CPB_B, PER_B));
        end
        if (prev_d[0] === 1'b0 && dout_a === 1'b1) last_rise[0] = cyc;
        if (prev_d[1] === 1'b0 && dout_b === 1'b1) last_rise[1] = cyc;
        prev_d[0] = dout_a;
        prev_d[1] = dout_b;
    end

    // Called on the first low sample of a message; decodes 7 bytes at bit
    // mid-points and checks the inter-byte gap and total message length.
    task automatic decode_msg(input int sel, input int cpb, input int exp_dur, input string tag);
        int c0, n;
        logic [7:0] by;
        c0 = cyc;
        for (int b = 0; b < 7; b++) begin
            if (b > 0) begin
                n = 0;
                while (sig(sel) !== 1'b0 && n < 4 * cpb) begin
                    @(negedge clk);
                    n++;
                end
                // From stop mid-point: rest of stop bit plus 2 idle cycles.
                check_int({tag, "_gap"}, n, cpb - cpb / 2 + 2);
            end
            repeat (cpb / 2) @(negedge clk);
            check_bit({tag, "_start_bit"}, sig(sel), 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (cpb) @(negedge clk);
                by[i] = sig(sel);
            end
            repeat (cpb) @(negedge clk);
            check_bit({tag, "_stop_bit"}, sig(sel), 1'b1);
            check_int({tag, "_byte"}, int'(by), int'(msg[b]));
        end
        check_int({tag, "_duration"}, last_rise[sel] + cpb - c0, exp_dur);
    endtask

    // Waits for a falling edge preceded by a high run longer than any run
    // inside a message; returns the cycle of the first low sample.
    task automatic wait_msg_start(input int sel, input int cpb, input int bound,
                                  input string tag, output int t);
        int run, n;
        run = 0;
        n   = 0;
        t   = -1;
        while (n < bound) begin
            @(negedge clk);
            n++;
            if (sig(sel) === 1'b1) begin
                run++;
            end else if (run > 9 * cpb + 2) begin
                t = cyc;
                break;
            end else begin
                run = 0;
            end
        end
        check_int({tag, "_found"}, (t >= 0) ? 1 : 0, 1);
    endtask

    task automatic release_and_find_start(input string tag);
        int n;
        rst = 1'b0;
        n   = 0;
        while (dout_a !== 1'b0 && n < 5) begin
            @(negedge clk);
            n++;
        end
        check_int({tag, "_latency_in_1_2"}, (n >= 1 && n <= 2) ? 1 : 0, 1);
    endtask

    initial begin
        int t1, t2, t3, f, b1, b2;

        f  = 100_000_000;
        b1 = 115_200;
        b2 = 9_600;
        check_int("cpb_default", uart_pkg::clks_per_bit(f, b1), 868);
        check_int("cpb_9600", uart_pkg::clks_per_bit(f, b2), 10416);

        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_bit("reset_dout_a", dout_a, 1'b1);
        check_bit("reset_dout_b", dout_b, 1'b1);

        release_and_find_start("first");
        t1 = cyc;
        decode_msg(0, CPB_A, 572, "a_msg1");
        wait_msg_start(0, CPB_A, 3 * PER_A, "a_msg2", t2);
        check_int("a_period_1_2", t2 - t1, 700);
        decode_msg(0, CPB_A, 572, "a_msg2");
        wait_msg_start(0, CPB_A, 3 * PER_A, "a_msg3", t3);
        check_int("a_period_2_3", t3 - t2, 700);

        // Byte 2 begins 164 cycles in; d3 spans 196..203.
        repeat (200) @(negedge clk);
        check_bit("pre_reset_d3", dout_a, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_bit("midframe_reset_dout", dout_a, 1'b1);
        repeat (2) @(negedge clk);
        release_and_find_start("after_mid");
        decode_msg(0, CPB_A, 572, "a_restart");

        // Abort inside a start bit, where the line is low.
        wait_msg_start(0, CPB_A, 3 * PER_A, "a_msg5", t1);
        repeat (3) @(negedge clk);
        check_bit("pre_abort_start", dout_a, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_bit("start_abort_dout", dout_a, 1'b1);
        @(negedge clk);
        release_and_find_start("after_abort");
        decode_msg(0, CPB_A, 572, "a_restart2");

        wait_msg_start(1, CPB_B, 3 * PER_B, "b_msg1", t1);
        decode_msg(1, CPB_B, 712, "b_msg1");
        wait_msg_start(1, CPB_B, 3 * PER_B, "b_msg2", t2);
        check_int("b_period", t2 - t1, 900);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
